bin_a_bcd_secuencial: RTL and testbench

- Converts the registered binary sum from the 3-digit adder stage into packed BCD digits for the display stage.
- Uses a sequential shift-add-3 (double-dabble) algorithm, one bit per clock, with a start/busy/done handshake.
- Sits directly downstream of the adder.
- Runs on the 27 MHz system clock.

---
 rtl/bin_a_bcd_secuencial.sv | 132 +++++++++++++
 tb/tb_bin_a_bcd_secuencial.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_a_bcd_secuencial.sv
// Sequential binary-to-BCD converter (shift-add-3, one input bit per clock).
// Takes the registered adder sum and produces packed BCD digits for the display.
module bin_a_bcd_secuencial #(
  parameter int IN_W   = 13,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [63:0]      BCD_MAX   = 64'(10 ** DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    shreg_q, shreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic               overflow_q, overflow_d;

  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_sh;

  // Every nibble that would reach 10 or more after doubling is pre-corrected by +3.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  function automatic logic exceeds_range(input logic [IN_W-1:0] v);
    return (64'(v) > BCD_MAX);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_flag_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_flag_q <= ovf_flag_d;
      overflow_q <= overflow_d;
    end
  end

  // Correct, then shift {scratch, shreg} left with the shreg MSB entering the units digit.
  always_comb begin
    scratch_adj = add3(scratch_q);
    scratch_sh  = (scratch_adj << 1) | BCD_W'(shreg_q[IN_W-1]);
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_flag_d = ovf_flag_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          shreg_d    = bin_in;
          scratch_d  = '0;
          cnt_d      = CNT_W'(IN_W);
          busy_d     = 1'b1;
          ovf_flag_d = exceeds_range(bin_in);
        end
      end
      SHIFT: begin
        shreg_d   = shreg_q << 1;
        scratch_d = scratch_sh;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Carries out of the top digit are lost, so out-of-range values saturate.
          bcd_d      = ovf_flag_q ? ALL_NINES : scratch_sh;
          overflow_d = ovf_flag_q;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_a_bcd_secuencial.sv
// Bench for bin_a_bcd_secuencial: 4-digit and 3-digit instances driven in parallel,
// directed scenarios plus random values checked against a decimal arithmetic model.
module tb_bin_a_bcd_secuencial;

  localparam int IN_W = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] bin_in;

  logic        busy4, done4, ov4;
  logic [15:0] bcd4;
  logic        busy3, done3, ov3;
  logic [11:0] bcd3;

  int nvec = 0;
  int nerr = 0;
  int dcnt4 = 0;
  int dcnt3 = 0;

  logic [15:0] prev4, prev3;
  logic        prevov4, prevov3;

  bin_a_bcd_secuencial #(.IN_W(13), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy4), .done(done4), .bcd(bcd4), .overflow(ov4)
  );

  bin_a_bcd_secuencial #(.IN_W(13), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ov3)
  );

  always #5 clk = ~clk;

  // Number of cycles in which done was high, as seen by each rising edge.
  always @(posedge clk) begin
    if (done4) dcnt4++;
    if (done3) dcnt3++;
  end

  function automatic logic [15:0] model_bcd(input int v, input int nd);
    int lim;
    int x;
    logic [15:0] r;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    r = '0;
    if (v >= lim) begin
      for (int i = 0; i < nd; i++) r = r | (16'h9 << (4 * i));
    end else begin
      x = v;
      for (int i = 0; i < nd; i++) begin
        r = r | (16'(x % 10) << (4 * i));
        x = x / 10;
      end
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int v, input int nd);
    int lim;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    return (v >= lim);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic start_conv(input int v);
    bin_in = v[12:0];
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 13'($urandom);
    chk("busy4_after_start", 32'(busy4), 32'd1);
    chk("busy3_after_start", 32'(busy3), 32'd1);
    chk("done4_low_after_start", 32'(done4), 32'd0);
    chk("bcd4_held", 32'(bcd4), 32'(prev4));
    chk("bcd3_held", 32'(bcd3), 32'(prev3[11:0]));
    chk("ov3_held", 32'(ov3), 32'(prevov3));
  endtask

  task automatic wait_done(input int v, input int k0);
    int k;
    k = k0;
    while (done4 !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), 32'(IN_W));
    chk("bcd4", 32'(bcd4), 32'(model_bcd(v, 4)));
    chk("ov4", 32'(ov4), 32'(model_ovf(v, 4)));
    chk("busy4_at_done", 32'(busy4), 32'd0);
    chk("done3", 32'(done3), 32'd1);
    chk("bcd3", 32'(bcd3), 32'(model_bcd(v, 3)));
    chk("ov3", 32'(ov3), 32'(model_ovf(v, 3)));
    chk("busy3_at_done", 32'(busy3), 32'd0);
    prev4   = model_bcd(v, 4);
    prev3   = model_bcd(v, 3);
    prevov4 = model_ovf(v, 4);
    prevov3 = model_ovf(v, 3);
  endtask

  task automatic single_conv(input int v);
    int d0;
    d0 = dcnt4;
    start_conv(v);
    wait_done(v, 0);
    @(negedge clk);
    chk("done4_one_cycle", 32'(done4), 32'd0);
    chk("done4_pulses", 32'(dcnt4 - d0), 32'd1);
  endtask

  initial begin
    int d0;
    int d3;
    int gap;
    int v;
    time t1;
    time t2;

    rst     = 1'b0;
    start   = 1'b0;
    bin_in  = '0;
    prev4   = '0;
    prev3   = '0;
    prevov4 = 1'b0;
    prevov3 = 1'b0;
    #1;
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_bcd4", 32'(bcd4), 32'd0);
    chk("rst_ov4", 32'(ov4), 32'd0);
    chk("rst_bcd3", 32'(bcd3), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Zero takes the full latency.
    single_conv(0);

    // Adder maximum.
    single_conv(1998);

    // Back-to-back: second start on the cycle right after done.
    start_conv(8191);
    wait_done(8191, 0);
    t1 = $time;
    start_conv(407);
    wait_done(407, 0);
    t2 = $time;
    chk("b2b_done_spacing", 32'((t2 - t1) / 10), 32'd14);
    @(negedge clk);

    // Start while busy is ignored.
    d0 = dcnt4;
    start_conv(555);
    repeat (4) @(negedge clk);
    bin_in = 13'd123;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(555, 5);
    @(negedge clk);
    chk("ignored_start_pulses", 32'(dcnt4 - d0), 32'd1);

    // Reset mid-conversion discards the partial result.
    single_conv(42);
    start_conv(300);
    repeat (6) @(negedge clk);
    d0 = dcnt4;
    d3 = dcnt3;
    rst = 1'b0;
    #1;
    chk("midrst_busy4", 32'(busy4), 32'd0);
    chk("midrst_bcd4", 32'(bcd4), 32'd0);
    chk("midrst_done4", 32'(done4), 32'd0);
    chk("midrst_bcd3", 32'(bcd3), 32'd0);
    prev4   = '0;
    prev3   = '0;
    prevov4 = 1'b0;
    prevov3 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_done4", 32'(dcnt4 - d0), 32'd0);
    chk("midrst_no_done3", 32'(dcnt3 - d3), 32'd0);
    chk("midrst_idle_bcd4", 32'(bcd4), 32'd0);
    single_conv(77);

    // Three-digit range edges.
    single_conv(1000);
    single_conv(999);

    // Random values with random idle gaps (gap 0 means back-to-back).
    for (int i = 0; i < 16; i++) begin
      v   = int'($urandom_range(0, 8191));
      gap = int'($urandom_range(0, 3));
      start_conv(v);
      wait_done(v, 0);
      repeat (gap) @(negedge clk);
    end
    @(negedge clk);
    chk("final_done_low", 32'(done4), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
